max7219_chain_driver: RTL
=========================

# max7219_chain_driver

Parametrised driver for a daisy chain of MAX7219 8×8 LED matrix controllers that tile a GRID_H×GRID_W pixel grid. It runs the full power-up register sequence, then refreshes the display continuously, one row command per chain transaction. Each frame is taken from a grid snapshot, and brightness and blanking can be changed at runtime. It sits between the game-logic grid register and the DIN/CS/LED_CLK pins, and generates LED_CLK as a registered, divided signal rather than a gated clock.

## Interface
- GRID_W, 16: grid width in pixels, a multiple of 8; TILES_X = GRID_W/8
- GRID_H, 16: grid height in pixels, a multiple of 8; TILES_Y = GRID_H/8; N_DEV = TILES_X*TILES_Y
- CLK_DIV, 2: half bit period in clk cycles, ≥1; bit period T = 2*CLK_DIV clk
- INIT_BRIGHT, 4'hF: intensity written during init
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  run frames while high
- grid  in  [GRID_H-1:0][GRID_W-1:0]  pixel bitmap; 1 = LED on
- brightness  in  4  new intensity value
- bright_we  in  1  one-cycle strobe that captures brightness
- blank  in  1  level; high = device shutdown mode
- DIN  out  1  serial data, MSB first
- CS  out  1  chain load; a rising edge latches all devices
- LED_CLK  out  1  serial clock
- busy  out  1  high while the init sequence is running or a transaction is in flight
- frame_done  out  1  one-cycle pulse after the row-8 transaction of a frame

## Operation
- Transaction: one 16-bit word per device, N_DEV*16 bits in total. The word for device N_DEV-1 (farthest from DIN) is shifted first. Each word is sent address byte first, then the data byte, MSB first.
- INIT states, in order:
  - display-test 0x0F←0x00
  - scan-limit 0x0B←0x07
  - decode 0x09←0x00
  - intensity 0x0A←INIT_BRIGHT
  - shutdown 0x0C←0x01
- All devices receive the same word during INIT. After INIT the FSM goes to IDLE.
- IDLE priority, highest first:
  - blank change: send a shutdown word, 0x00 when blanking, 0x01 when unblanking.
  - pending intensity: send 0x0A←latched value.
  - enable && !blank: go to SNAP.
- SNAP: copy grid into the frame buffer (one cycle). Then ROW r = 0..7, each with address r+1.
- Pixel mapping: device d covers tile ty = d / TILES_X, tx = d % TILES_X. Data bit k = fb[ty*8+r][tx*8+k].
- After ROW 7: pulse frame_done and return to IDLE.
- bright_we captures the value into a pending register at any time. If several writes arrive before service, only the last value is sent. The update is applied between frames, never mid-frame.
- enable deasserted mid-frame: the current frame completes, then the FSM idles with CS=1.
- blank asserted mid-frame: the frame completes, then shutdown is sent.
- reset at any point: outputs go to their reset values immediately and INIT reruns.
- Changes to grid after SNAP are not shown until the next frame.

## Timing
- Reset values: DIN=0, CS=1, LED_CLK=0, busy=1, frame_done=0.
- Release: INIT starts on the first clk edge after reset deasserts.
- Per bit: CS is low; DIN is updated while LED_CLK=0; LED_CLK is low for CLK_DIV cycles, then high for CLK_DIV cycles. The device samples on the rising edge.
- After the last bit: LED_CLK=0 and CS stays low for 1 T. CS then goes high for 1 T, which latches the devices.
- Transaction length = (16*N_DEV + 2)*T.
- Default timings: 264 clk per transaction, 1320 clk for INIT, 2112 clk per frame, plus 1 clk for SNAP and 1 clk for IDLE decision.
- busy stays high from transaction start through the end of the CS-high interval.
- LED_CLK and DIN are driven directly from flops; no combinational path from clk.

## Structure
- Package max7219_pkg holds:
  - register address constants (NOOP, DIGIT0, DECODE, INTENSITY, SCANLIM, SHUTDOWN, DISPTEST)
  - the FSM state enum (INIT, IDLE, SNAP, ROW, BLANK_CMD, BRIGHT_CMD)
  - a cmd_word_t typedef (addr, data bytes)
- Sub-module max7219_shifter handles serialisation only:
  - loads an N_DEV*16-bit word on start
  - generates DIN, CS and LED_CLK with the divider
  - returns done after the CS-high interval
- The top level contains the sequencing FSM, the frame buffer, the word assembly, and the pending brightness and blank registers.

## Test plan
- Reset release, defaults: the bench decodes the first 5 transactions as 0x0F00, 0x0B07, 0x0900, 0x0A0F, 0x0C01 ×4 devices. It then sees 8 row words with addresses 0x01..0x08, and frame_done at 1320+2+2112 clk ±2.
- Single pixel: grid[9][3]=1, all else 0. In ROW r=1, device 2 (ty=1, tx=0) sends 0x0208; every other data byte in the frame is 0x00.
- Snapshot isolation: toggle grid every 50 clk during a frame. The decoded frame equals the grid value at the SNAP cycle.
- Brightness coalescing: bright_we with 3, then 7, in the same frame. Exactly one 0x0A07 transaction is sent, before the next frame's SNAP.
- Blank: raise blank mid-frame. The frame completes, then 0x0C00 is sent and no rows follow. Lowering blank sends 0x0C01, then rows resume.
- Reset mid-transaction, with CLK_DIV=1, GRID_W=32, GRID_H=8 (N_DEV=4): outputs return to their reset values in the same cycle, and INIT reruns completely with a 66-bit-period transaction length.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 chain driver: register map, sequencer
// states and the per-device command word layout.
package max7219_pkg;

  localparam logic [7:0] NOOP      = 8'h00;
  localparam logic [7:0] DIGIT0    = 8'h01;
  localparam logic [7:0] DECODE    = 8'h09;
  localparam logic [7:0] INTENSITY = 8'h0A;
  localparam logic [7:0] SCANLIM   = 8'h0B;
  localparam logic [7:0] SHUTDOWN  = 8'h0C;
  localparam logic [7:0] DISPTEST  = 8'h0F;

  localparam int N_INIT = 5;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    SNAP,
    ROW,
    BLANK_CMD,
    BRIGHT_CMD
  } state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_word_t;

  // Power-up register sequence, broadcast to every device in the chain.
  function automatic cmd_word_t init_cmd(input logic [2:0] step, input logic [3:0] bright);
    cmd_word_t c;
    case (step)
      3'd0:    begin c.addr = DISPTEST;  c.data = 8'h00;           end
      3'd1:    begin c.addr = SCANLIM;   c.data = 8'h07;           end
      3'd2:    begin c.addr = DECODE;    c.data = 8'h00;           end
      3'd3:    begin c.addr = INTENSITY; c.data = {4'h0, bright};  end
      default: begin c.addr = SHUTDOWN;  c.data = 8'h01;           end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/max7219_chain_driver_if.sv
// Serial pin bundle between the chain driver and the MAX7219 daisy chain.
interface max7219_chain_driver_if;
  logic DIN;
  logic CS;
  logic LED_CLK;

  modport master (output DIN, output CS, output LED_CLK);
  modport slave  (input DIN, input CS, input LED_CLK);
endinterface

// File: rtl/max7219_shifter.sv
// Serialises one chain-wide word: bits at period T = 2*CLK_DIV, then one T of
// CS low with LED_CLK idle and one T of CS high to latch the devices.
module max7219_shifter #(
  parameter int N_DEV   = 4,
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N_DEV*16-1:0]   word,
  output logic                  active,
  output logic                  done,
  max7219_chain_driver_if.master pins
);
  localparam int NB = N_DEV * 16;
  localparam int BW = $clog2(NB + 2);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(NB - 1);
  localparam logic [BW-1:0] TAIL_LO  = BW'(NB);
  localparam logic [BW-1:0] TAIL_HI  = BW'(NB + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [NB-1:0] shift_reg;
  logic [BW-1:0] bit_reg;
  logic [DW-1:0] div_reg;
  logic          half_reg;
  logic          active_reg;
  logic          din_reg;
  logic          cs_reg;
  logic          sclk_reg;

  // Last cycle of the CS-high interval; a new start may be accepted here.
  assign done   = active_reg && (bit_reg == TAIL_HI) && half_reg && (div_reg == DIV_LAST);
  assign active = active_reg;

  assign pins.DIN     = din_reg;
  assign pins.CS      = cs_reg;
  assign pins.LED_CLK = sclk_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg  <= '0;
      bit_reg    <= '0;
      div_reg    <= '0;
      half_reg   <= 1'b0;
      active_reg <= 1'b0;
      din_reg    <= 1'b0;
      cs_reg     <= 1'b1;
      sclk_reg   <= 1'b0;
    end else if (start) begin
      shift_reg  <= word;
      din_reg    <= word[NB-1];
      bit_reg    <= '0;
      div_reg    <= '0;
      half_reg   <= 1'b0;
      active_reg <= 1'b1;
      cs_reg     <= 1'b0;
      sclk_reg   <= 1'b0;
    end else if (active_reg) begin
      if (div_reg != DIV_LAST) begin
        div_reg <= div_reg + 1'b1;
      end else begin
        div_reg  <= '0;
        half_reg <= ~half_reg;
        if (!half_reg) begin
          if (bit_reg < TAIL_LO) sclk_reg <= 1'b1;
        end else begin
          sclk_reg <= 1'b0;
          bit_reg  <= bit_reg + 1'b1;
          if (bit_reg < LAST_BIT) begin
            shift_reg <= {shift_reg[NB-2:0], 1'b0};
            din_reg   <= shift_reg[NB-2];
          end
          if (bit_reg == LAST_BIT) din_reg    <= 1'b0;
          if (bit_reg == TAIL_LO)  cs_reg     <= 1'b1;
          if (bit_reg == TAIL_HI)  active_reg <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/max7219_chain_driver.sv
// Sequencer for a tiled MAX7219 chain: power-up init, blank/brightness
// service between frames, and row-by-row refresh from a grid snapshot.
module max7219_chain_driver
  import max7219_pkg::*;
#(
  parameter int         GRID_W      = 16,
  parameter int         GRID_H      = 16,
  parameter int         CLK_DIV     = 2,
  parameter logic [3:0] INIT_BRIGHT = 4'hF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [GRID_H-1:0][GRID_W-1:0] grid,
  input  logic [3:0]                    brightness,
  input  logic                          bright_we,
  input  logic                          blank,
  max7219_chain_driver_if.master        pins,
  output logic                          busy,
  output logic                          frame_done
);
  localparam int TILES_X = GRID_W / 8;
  localparam int TILES_Y = GRID_H / 8;
  localparam int N_DEV   = TILES_X * TILES_Y;
  localparam int RW      = $clog2(GRID_H);

  state_t state_reg, state_next;
  logic [2:0] idx_reg, idx_next;
  logic [GRID_H-1:0][GRID_W-1:0] fb_reg;
  logic [GRID_H-1:0][GRID_W-1:0] frame_src;
  logic [3:0] bright_val_reg;
  logic       bright_pending_reg;
  logic       blank_applied_reg;
  logic       frame_done_reg;

  cmd_word_t             cmd;
  logic [N_DEV*16-1:0]   word;
  logic                  sh_start;
  logic                  sh_active;
  logic                  sh_done;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    case (state_reg)
      INIT: if (sh_done) begin
        if (idx_reg == 3'(N_INIT - 1)) begin
          state_next = IDLE;
          idx_next   = 3'd0;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      IDLE: begin
        if (blank != blank_applied_reg)  state_next = BLANK_CMD;
        else if (bright_pending_reg)     state_next = BRIGHT_CMD;
        else if (enable && !blank)       state_next = SNAP;
      end
      SNAP: begin
        state_next = ROW;
        idx_next   = 3'd0;
      end
      ROW: if (sh_done) begin
        if (idx_reg == 3'd7) begin
          state_next = IDLE;
          idx_next   = 3'd0;
        end else begin
          idx_next = idx_reg + 3'd1;
        end
      end
      BLANK_CMD, BRIGHT_CMD: if (sh_done) state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // The word is built for the upcoming state so back-to-back transactions
  // launch on the same edge that retires the previous one.
  assign sh_start = (state_next inside {INIT, ROW, BLANK_CMD, BRIGHT_CMD}) &&
                    (!sh_active || sh_done);

  always_comb begin
    cmd.addr = NOOP;
    cmd.data = 8'h00;
    case (state_next)
      INIT:       cmd = init_cmd(idx_next, INIT_BRIGHT);
      BLANK_CMD:  begin cmd.addr = SHUTDOWN;  cmd.data = blank ? 8'h00 : 8'h01; end
      BRIGHT_CMD: begin cmd.addr = INTENSITY; cmd.data = {4'h0, bright_val_reg}; end
      ROW:        cmd.addr = DIGIT0 + {5'b0, idx_next};
      default:    ;
    endcase
  end

  // Row 0 launches during SNAP, before fb_reg holds the snapshot.
  assign frame_src = (state_reg == SNAP) ? grid : fb_reg;

  for (genvar gi = 0; gi < N_DEV; gi++) begin : g_dev
    localparam int TY = gi / TILES_X;
    localparam int TX = gi % TILES_X;
    logic [RW-1:0] row_idx;
    logic [7:0]    row_bits;
    assign row_idx  = RW'(TY * 8) + RW'(idx_next);
    assign row_bits = frame_src[row_idx][TX*8 +: 8];
    assign word[gi*16 +: 16] = (state_next == ROW) ? {cmd.addr, row_bits} : {cmd.addr, cmd.data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= INIT;
      idx_reg            <= 3'd0;
      fb_reg             <= '0;
      bright_val_reg     <= INIT_BRIGHT;
      bright_pending_reg <= 1'b0;
      blank_applied_reg  <= 1'b0;
      frame_done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      if (state_reg == SNAP) fb_reg <= grid;
      if (bright_we) begin
        bright_val_reg     <= brightness;
        bright_pending_reg <= 1'b1;
      end else if (state_reg == IDLE && state_next == BRIGHT_CMD) begin
        bright_pending_reg <= 1'b0;
      end
      if (state_reg == IDLE && state_next == BLANK_CMD) blank_applied_reg <= blank;
      frame_done_reg <= (state_reg == ROW) && (idx_reg == 3'd7) && sh_done;
    end
  end

  assign busy       = (state_reg == INIT) || sh_active;
  assign frame_done = frame_done_reg;

  max7219_shifter #(
    .N_DEV   (N_DEV),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .start  (sh_start),
    .word   (word),
    .active (sh_active),
    .done   (sh_done),
    .pins   (pins)
  );
endmodule
